// File: rtl/fifo_pkg.sv
// Types and helpers shared by the FIFO producer/consumer blocks.
package fifo_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} burst_rd_state_t;

    // Width of a word index that counts 0..n-1. Never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register buffer with valid/ready on both sides.
// The head entry drives the output directly, so the outputs are registered.
module skid_buf2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   occ_q, occ_d;
    logic         push, pop;

    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = head_q;
    assign occ       = occ_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = in_data;
                end else begin
                    tail_d = in_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            // Simultaneous push and pop only happens with one entry held.
            2'b11: head_d = in_data;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a sync FIFO into a valid/ready stream framed into fixed-length bursts.
// fifo_pop depends only on registered state, never on fifo_vld or out_ready.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DW        = 24,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              fifo_vld,
    input  logic [DW-1:0]     fifo_data,
    output logic              fifo_pop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy,
    output logic [STAT_W-1:0] burst_cnt
);

    localparam int unsigned    IW       = idx_width(BURST_LEN);
    localparam logic [IW-1:0]  LAST_IDX = IW'(BURST_LEN - 1);

    burst_rd_state_t   state_q, state_d;
    logic [IW-1:0]     widx_q, widx_d;
    logic [STAT_W-1:0] cnt_q;
    logic              take, lst;
    logic              buf_in_ready;
    logic [1:0]        occ;
    logic [DW+1:0]     buf_in, buf_out;

    assign fifo_pop = (state_q != IDLE) && buf_in_ready;
    assign take     = fifo_pop && fifo_vld;
    assign lst      = take && (widx_q == LAST_IDX);
    assign buf_in   = {widx_q == '0, widx_q == LAST_IDX, fifo_data};

    skid_buf2 #(
        .W (DW + 2)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (take),
        .in_ready  (buf_in_ready),
        .in_data   (buf_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out),
        .occ       (occ)
    );

    assign out_sop   = buf_out[DW+1];
    assign out_eop   = buf_out[DW];
    assign out_data  = buf_out[DW-1:0];
    assign busy      = (state_q != IDLE) || (occ != 2'd0);
    assign burst_cnt = cnt_q;

    always_comb begin
        widx_d = widx_q;
        if (take) begin
            widx_d = lst ? '0 : widx_q + 1'b1;
        end
    end

    // Leaving RUN mid-burst goes through FINISH so IDLE is only entered on a boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en) state_d = ((widx_q == '0) && !take) ? IDLE : FINISH;
            end
            FINISH: begin
                if (lst) begin
                    state_d = en ? RUN : IDLE;
                end else if (en) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            widx_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            if (out_valid && out_ready && out_eop) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench: instance A (BURST_LEN=4) for framing/stall/reset cases,
// instance B (BURST_LEN=1, STAT_W=4) for single-word bursts and counter wrap.
module tb_fifo_burst_reader;

    localparam int DW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          a_en, a_vld, a_pop, a_ovalid, a_ordy, a_sop, a_eop, a_busy;
    logic [DW-1:0] a_data, a_odata;
    logic [15:0]   a_cnt;
    logic          b_en, b_vld, b_pop, b_ovalid, b_ordy, b_sop, b_eop, b_busy;
    logic [DW-1:0] b_data, b_odata;
    logic [3:0]    b_cnt;

    fifo_burst_reader #(
        .DW        (DW),
        .BURST_LEN (4),
        .STAT_W    (16)
    ) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (a_en),
        .fifo_vld  (a_vld),
        .fifo_data (a_data),
        .fifo_pop  (a_pop),
        .out_valid (a_ovalid),
        .out_ready (a_ordy),
        .out_data  (a_odata),
        .out_sop   (a_sop),
        .out_eop   (a_eop),
        .busy      (a_busy),
        .burst_cnt (a_cnt)
    );

    fifo_burst_reader #(
        .DW        (DW),
        .BURST_LEN (1),
        .STAT_W    (4)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (b_en),
        .fifo_vld  (b_vld),
        .fifo_data (b_data),
        .fifo_pop  (b_pop),
        .out_valid (b_ovalid),
        .out_ready (b_ordy),
        .out_data  (b_odata),
        .out_sop   (b_sop),
        .out_eop   (b_eop),
        .busy      (b_busy),
        .burst_cnt (b_cnt)
    );

    int checks = 0;
    int errors = 0;

    // FIFO contents, words taken but not yet delivered, and burst position.
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [DW-1:0] ta[$];
    logic [DW-1:0] tb_q[$];
    int            pos_a = 0;
    int            dlv_a = 0;
    int            dlv_b = 0;
    logic          src_on = 1'b1;
    logic [DW-1:0] last_eop_a = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        a_vld  = src_on && (qa.size() > 0);
        a_data = (qa.size() > 0) ? qa[0] : '0;
        b_vld  = src_on && (qb.size() > 0);
        b_data = (qb.size() > 0) ? qb[0] : '0;
    endtask

    // One clock: score deliveries, model FIFO pops, then sample 1 ns after the edge.
    task automatic tick();
        logic tka, dla, tkb, dlb;
        logic [DW-1:0] w;
        refresh();
        tka = a_pop && a_vld && rst_n;
        dla = a_ovalid && a_ordy && rst_n;
        tkb = b_pop && b_vld && rst_n;
        dlb = b_ovalid && b_ordy && rst_n;
        if (dla) begin
            check("a_word_pending", 32'(ta.size() > 0), 32'd1);
            if (ta.size() > 0) begin
                w = ta.pop_front();
                check("a_data_order", 32'(a_odata), 32'(w));
                check("a_sop", 32'(a_sop), 32'(pos_a == 0));
                check("a_eop", 32'(a_eop), 32'(pos_a == 3));
            end
            if (a_eop) last_eop_a = a_odata;
            pos_a = (pos_a + 1) % 4;
            dlv_a++;
        end
        if (dlb) begin
            check("b_word_pending", 32'(tb_q.size() > 0), 32'd1);
            if (tb_q.size() > 0) begin
                w = tb_q.pop_front();
                check("b_data_order", 32'(b_odata), 32'(w));
            end
            check("b_sop", 32'(b_sop), 32'd1);
            check("b_eop", 32'(b_eop), 32'd1);
            dlv_b++;
        end
        if (tka) begin
            ta.push_back(a_data);
            void'(qa.pop_front());
        end
        if (tkb) begin
            tb_q.push_back(b_data);
            void'(qb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input int target);
        int n = 0;
        while (dlv_a < target && n < 200) begin
            tick();
            n++;
        end
        check("a_delivered_count", 32'(dlv_a), 32'(target));
    endtask

    task automatic run_b(input int target);
        int n = 0;
        while (dlv_b < target && n < 200) begin
            tick();
            n++;
        end
        check("b_delivered_count", 32'(dlv_b), 32'(target));
    endtask

    initial begin
        rst_n  = 1'b0;
        a_en   = 1'b0;
        a_ordy = 1'b0;
        b_en   = 1'b0;
        b_ordy = 1'b0;
        refresh();
        tick();
        tick();

        // Reset state
        check("rst_pop", 32'(a_pop), 32'd0);
        check("rst_valid", 32'(a_ovalid), 32'd0);
        check("rst_data", 32'(a_odata), 32'd0);
        check("rst_sop", 32'(a_sop), 32'd0);
        check("rst_eop", 32'(a_eop), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_cnt", 32'(a_cnt), 32'd0);
        check("rst_b_cnt", 32'(b_cnt), 32'd0);
        rst_n = 1'b1;

        // Two full bursts in order
        for (int i = 1; i <= 8; i++) qa.push_back(DW'(i));
        a_en   = 1'b1;
        a_ordy = 1'b1;
        tick();
        check("t1_pop_in_run", 32'(a_pop), 32'd1);
        check("t1_no_valid_yet", 32'(a_ovalid), 32'd0);
        tick();
        check("t1_first_valid", 32'(a_ovalid), 32'd1);
        check("t1_first_data", 32'(a_odata), 32'h1);
        check("t1_first_sop", 32'(a_sop), 32'd1);
        check("t1_busy", 32'(a_busy), 32'd1);
        run_a(8);
        check("t1_burst_cnt", 32'(a_cnt), 32'd2);
        check("t1_last_eop", 32'(last_eop_a), 32'h8);

        // en drops mid-burst: the burst still completes
        for (int i = 0; i < 10; i++) qa.push_back(DW'(32'h11 + i));
        tick();
        tick();
        check("t2_two_taken", 32'(qa.size()), 32'd8);
        a_en = 1'b0;
        tick();
        tick();
        check("t2_pop_off", 32'(a_pop), 32'd0);
        repeat (3) tick();
        check("t2_remaining", 32'(qa.size()), 32'd6);
        check("t2_pop_still_off", 32'(a_pop), 32'd0);
        check("t2_idle", 32'(a_busy), 32'd0);
        check("t2_burst_cnt", 32'(a_cnt), 32'd3);
        check("t2_delivered", 32'(dlv_a), 32'd12);
        check("t2_last_eop", 32'(last_eop_a), 32'h14);

        // Downstream stall: buffer fills, pop drops, output held
        a_en   = 1'b1;
        a_ordy = 1'b0;
        tick();
        tick();
        tick();
        check("t3_pop_full", 32'(a_pop), 32'd0);
        check("t3_valid", 32'(a_ovalid), 32'd1);
        check("t3_data", 32'(a_odata), 32'h15);
        tick();
        tick();
        check("t3_data_held", 32'(a_odata), 32'h15);
        check("t3_sop_held", 32'(a_sop), 32'd1);
        check("t3_pop_held_off", 32'(a_pop), 32'd0);
        check("t3_fifo_left", 32'(qa.size()), 32'd4);
        a_ordy = 1'b1;
        run_a(18);
        check("t3_burst_cnt", 32'(a_cnt), 32'd4);
        check("t3_fifo_empty", 32'(qa.size()), 32'd0);

        // FIFO empty after word 2 of 4: stall without timeout or early eop
        repeat (20) tick();
        check("t4_pop_waiting", 32'(a_pop), 32'd1);
        check("t4_no_valid", 32'(a_ovalid), 32'd0);
        check("t4_busy", 32'(a_busy), 32'd1);
        check("t4_cnt_before", 32'(a_cnt), 32'd4);
        qa.push_back(DW'(32'h1B));
        qa.push_back(DW'(32'h1C));
        run_a(20);
        check("t4_cnt_after", 32'(a_cnt), 32'd5);
        check("t4_last_eop", 32'(last_eop_a), 32'h1C);

        // Reset with two words buffered
        a_ordy = 1'b0;
        for (int i = 0; i < 4; i++) qa.push_back(DW'(32'h21 + i));
        tick();
        tick();
        check("t5_full", 32'(a_pop), 32'd0);
        rst_n  = 1'b0;
        src_on = 1'b0;
        tick();
        check("t5_pop", 32'(a_pop), 32'd0);
        check("t5_valid", 32'(a_ovalid), 32'd0);
        check("t5_data", 32'(a_odata), 32'd0);
        check("t5_sop", 32'(a_sop), 32'd0);
        check("t5_eop", 32'(a_eop), 32'd0);
        check("t5_busy", 32'(a_busy), 32'd0);
        check("t5_cnt", 32'(a_cnt), 32'd0);
        ta.delete();
        pos_a  = 0;
        rst_n  = 1'b1;
        src_on = 1'b1;
        a_ordy = 1'b1;
        tick();
        tick();
        check("t5_post_valid", 32'(a_ovalid), 32'd1);
        check("t5_post_data", 32'(a_odata), 32'h23);
        check("t5_post_sop", 32'(a_sop), 32'd1);
        check("t5_post_eop", 32'(a_eop), 32'd0);
        run_a(22);

        // Single-word bursts, 4-bit counter wraps after 16
        for (int i = 0; i < 17; i++) qb.push_back(DW'(32'h100 + i));
        b_en   = 1'b1;
        b_ordy = 1'b1;
        run_b(17);
        check("t6_cnt_wrap", 32'(b_cnt), 32'd1);
        check("t6_fifo_empty", 32'(qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
